// File: rtl/adc_readout_sm.sv
// adc_readout_sm: readout-side parser for one stored ADC fill.
// Pops a fill (fill header, per-waveform header + data bursts, checksum) from an
// FWFT FIFO, forwards every word through a one-deep valid/ready output register
// tagged with its type, and recomputes the 32-bit lane checksum.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for rd_start
// FILL_HDR | forwarding fill header, latching burst/waveform counts
// WFM_HDR  | forwarding a waveform header, loading the burst counter
// DATA     | forwarding data bursts, accumulating the running sum
// CKSUM    | forwarding the checksum word and comparing against the sum
// DRAIN    | waiting for the checksum word to be accepted downstream
module adc_readout_sm #(
    parameter int BURST_CNT_W = 24,
    parameter int WFM_CNT_W   = 12
) (
    input  logic         clk,
    input  logic         reset_clk50,
    input  logic         rd_start,
    input  logic [127:0] fifo_dout,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    output logic [127:0] out_data,
    output logic [1:0]   out_type,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         checksum_err,
    output logic [31:0]  fill_cntr,
    output logic         rd_done,
    output logic         sm_idle
);

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_FILL_HDR = 6'b000010,
        S_WFM_HDR  = 6'b000100,
        S_DATA     = 6'b001000,
        S_CKSUM    = 6'b010000,
        S_DRAIN    = 6'b100000
    } state_t;

    state_t                 state_q, state_d;
    logic [BURST_CNT_W-1:0] bursts_q, bursts_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [WFM_CNT_W-1:0]   wfm_cnt_q, wfm_cnt_d;
    logic [31:0]            sum_q, sum_d;
    logic [127:0]           out_data_q, out_data_d;
    logic [1:0]             out_type_q, out_type_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   cksum_err_q, cksum_err_d;
    logic [31:0]            fill_cntr_q, fill_cntr_d;
    logic                   rd_done_q, rd_done_d;

    logic                   xfer_state;
    logic                   fire;
    logic [1:0]             type_code;
    logic [31:0]            lane_sum;
    logic [WFM_CNT_W-1:0]   wfm_rem;
    logic [WFM_CNT_W-1:0]   hdr_wfms;
    state_t                 eow_state;

    // Transfer handshake, word tagging and next-state / datapath updates.
    always_comb begin
        state_d     = state_q;
        bursts_d    = bursts_q;
        burst_cnt_d = burst_cnt_q;
        wfm_cnt_d   = wfm_cnt_q;
        sum_d       = sum_q;
        out_data_d  = out_data_q;
        out_type_d  = out_type_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        cksum_err_d = cksum_err_q;
        fill_cntr_d = fill_cntr_q;
        rd_done_d   = 1'b0;

        xfer_state = (state_q == S_FILL_HDR) || (state_q == S_WFM_HDR) ||
                     (state_q == S_DATA)     || (state_q == S_CKSUM);
        // Reset wins over any pop in the same cycle, so a fill abandoned by
        // reset leaves its remaining words in the FIFO.
        fire = xfer_state && !fifo_empty && (!out_valid_q || out_ready) && !reset_clk50;

        case (state_q)
            S_WFM_HDR: type_code = 2'd1;
            S_DATA:    type_code = 2'd2;
            S_CKSUM:   type_code = 2'd3;
            default:   type_code = 2'd0;
        endcase

        lane_sum = fifo_dout[31:0] + fifo_dout[63:32] + fifo_dout[95:64] + fifo_dout[127:96];
        hdr_wfms = fifo_dout[BURST_CNT_W+WFM_CNT_W-1:BURST_CNT_W];

        // End-of-waveform decision; counter is zero-tested before decrement.
        wfm_rem   = (wfm_cnt_q != '0) ? wfm_cnt_q - 1'b1 : '0;
        eow_state = (wfm_rem != '0) ? S_WFM_HDR : S_CKSUM;

        if (fire) begin
            out_data_d  = fifo_dout;
            out_type_d  = type_code;
            out_valid_d = 1'b1;
            out_last_d  = (state_q == S_CKSUM);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (rd_start) begin
                    state_d     = S_FILL_HDR;
                    cksum_err_d = 1'b0;
                    sum_d       = '0;
                end
            end
            S_FILL_HDR: begin
                if (fire) begin
                    bursts_d  = fifo_dout[BURST_CNT_W-1:0];
                    wfm_cnt_d = hdr_wfms;
                    state_d   = (hdr_wfms != '0) ? S_WFM_HDR : S_CKSUM;
                end
            end
            S_WFM_HDR: begin
                if (fire) begin
                    burst_cnt_d = bursts_q;
                    if (bursts_q != '0) begin
                        state_d = S_DATA;
                    end else begin
                        wfm_cnt_d = wfm_rem;
                        state_d   = eow_state;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    sum_d = sum_q + lane_sum;
                    if (burst_cnt_q != '0) begin
                        burst_cnt_d = burst_cnt_q - 1'b1;
                    end
                    if (burst_cnt_q <= BURST_CNT_W'(1)) begin
                        wfm_cnt_d = wfm_rem;
                        state_d   = eow_state;
                    end
                end
            end
            S_CKSUM: begin
                if (fire) begin
                    cksum_err_d = (fifo_dout[31:0] != sum_q);
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    rd_done_d   = 1'b1;
                    fill_cntr_d = fill_cntr_q + 32'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_clk50) begin
            state_q     <= S_IDLE;
            bursts_q    <= '0;
            burst_cnt_q <= '0;
            wfm_cnt_q   <= '0;
            sum_q       <= '0;
            out_data_q  <= '0;
            out_type_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cksum_err_q <= 1'b0;
            fill_cntr_q <= '0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bursts_q    <= bursts_d;
            burst_cnt_q <= burst_cnt_d;
            wfm_cnt_q   <= wfm_cnt_d;
            sum_q       <= sum_d;
            out_data_q  <= out_data_d;
            out_type_q  <= out_type_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cksum_err_q <= cksum_err_d;
            fill_cntr_q <= fill_cntr_d;
            rd_done_q   <= rd_done_d;
        end
    end

    assign fifo_rd_en   = fire;
    assign out_data     = out_data_q;
    assign out_type     = out_type_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign checksum_err = cksum_err_q;
    assign fill_cntr    = fill_cntr_q;
    assign rd_done      = rd_done_q;
    assign sm_idle      = (state_q == S_IDLE);

endmodule

// File: doc/adc_readout_sm.md
Name: adc_readout_sm

Overview:
- Consumer-side counterpart of the ADC acquisition state machine.
- Reads one stored fill from the readout FIFO (first-word-fall-through, fed from DDR3) and parses it. The fill is: fill header, then per waveform a waveform header and its data bursts, then a checksum word.
- Forwards every word to the readout link through a one-deep valid/ready output register and tags each word with its type.
- Recomputes the checksum and flags a mismatch. Runs in readout mode, when both acq_enable inputs are low.

Parameters:
- BURST_CNT_W, 24, width of the burst-count field (128-bit data words per waveform).
- WFM_CNT_W, 12, width of the waveform-count field.

Ports:
- clk  input  1  system clock
- reset_clk50  input  1  synchronous active-high reset
- rd_start  input  1  one-cycle pulse: begin reading one fill
- fifo_dout  input  128  FIFO head word (FWFT)
- fifo_empty  input  1  FIFO empty
- fifo_rd_en  output  1  pop FIFO head
- out_data  output  128  forwarded word
- out_type  output  2  0=fill hdr, 1=wfm hdr, 2=data, 3=checksum
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts when high with out_valid
- out_last  output  1  high with the checksum word
- checksum_err  output  1  sticky mismatch flag, cleared on rd_start
- fill_cntr  output  32  fills completed since reset
- rd_done  output  1  one-cycle pulse at end of fill
- sm_idle  output  1  high in IDLE

Behaviour:
- Reset: synchronous. All outputs return to 0 except sm_idle=1. State goes to IDLE. Internal counters and the running sum clear. Reset mid-fill abandons the fill with no rd_done and leaves the remaining FIFO words unpopped.
- Transfer rule: fire = (state in FILL_HDR, WFM_HDR, DATA, CKSUM) && !fifo_empty && (!out_valid || out_ready).
  - fifo_rd_en = fire, combinational.
  - On fire: out_data<=fifo_dout, out_type<=state code, out_valid<=1, out_last<=(state==CKSUM).
  - Without fire: if out_ready, out_valid<=0 (and out_last<=0).
  - Throughput is 1 word/cycle with out_ready held high. Latency is 1 clk from FIFO head to out_valid.
- State machine (one-hot):
  - IDLE: on rd_start, go to FILL_HDR and clear checksum_err and the sum. rd_start is ignored in every other state.
  - FILL_HDR: on fire, latch bursts=fifo_dout[BURST_CNT_W-1:0] and wfms=fifo_dout[BURST_CNT_W+WFM_CNT_W-1:BURST_CNT_W]. Go to WFM_HDR if wfms!=0, else CKSUM.
  - WFM_HDR: on fire, load the burst counter with bursts. Go to DATA if bursts!=0, else take the end-of-waveform decision.
  - DATA: on fire, add the four 32-bit lanes to the running sum (mod 2^32) and decrement the burst counter. When the last burst fires, take the end-of-waveform decision.
  - End-of-waveform decision: decrement the waveform counter. Go to WFM_HDR if the remaining count is non-zero, else CKSUM.
  - CKSUM: on fire, checksum_err<=(fifo_dout[31:0]!=running sum). fifo_dout[127:32] is forwarded unchecked. Go to DRAIN.
  - DRAIN: wait until !out_valid || out_ready, i.e. the checksum word is accepted. Then pulse rd_done for 1 clk, increment fill_cntr (wraps at 2^32), and go to IDLE.
- Counter rules:
  - The burst counter is BURST_CNT_W bits and the waveform counter is WFM_CNT_W bits. Neither wraps: both are tested for zero before decrement.
  - The running sum is 32 bits and wraps.
- Boundary conditions:
  - fifo_empty mid-fill stalls in place with no timeout. out_valid still drains normally.
  - out_ready low holds out_data, out_type and out_last stable and blocks pops.
  - A simultaneous accept and fire in the same cycle keeps out_valid=1 with the new word.
  - rd_start in the same cycle as reset: reset wins.

Test Plan:
- Nominal fill: rd_start. FIFO holds a fill header with wfms=2, bursts=3; six data words each 0x00000001 in all four lanes; checksum word [31:0]=0x18. Required: 10 words out with out_type 0,1,2,2,2,1,2,2,2,3; out_last only on the 10th; checksum_err=0; rd_done 1 clk after the last accept; fill_cntr=1.
- Checksum mismatch: same fill with checksum word [31:0]=0x17. Required: checksum_err=1 after the CKSUM pop, held until the next rd_start; rd_done still pulses once.
- Degenerate counts: wfms=0 gives 2 words (types 0,3) with sum 0 checked against 0x0. wfms=1, bursts=0 gives 3 words (types 0,1,3).
- Backpressure and starvation: out_ready toggled 1010… and fifo_empty randomly asserted during the nominal fill. Required: identical 10-word sequence with no loss or duplication; fifo_rd_en never high while fifo_empty or while (out_valid && !out_ready).
- Reset mid-fill: assert reset_clk50 for 1 clk after the 4th word. Required: next cycle out_valid=0, sm_idle=1, no rd_done, fill_cntr=0. A following rd_start with a fresh fill completes normally.
- rd_start while busy: pulse rd_start during DATA. Required: no state change and checksum_err not cleared.
